// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART_LITE serial path (uart_tx / uart_rx).
//   - DEFAULT_CLKS_PER_BIT : baud divisor shared by transmitter and receiver so
//                            the pair can be looped back without retuning
//   - DATA_BITS, STOP_BITS : 8N1 frame format
//   - rx_state_t           : receiver FSM state encoding
// No ports; this is a package.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 100 MHz system clock divided down to 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // 8N1 frame: one start bit, eight data bits LSB first, one stop bit.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver states. BREAK parks the receiver while the line is held low
    // after a bad stop bit, so a break condition is not decoded as 0x00 bytes.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchroniser that brings the asynchronous serial pin into the
// clk domain. Flops reset to 1 so the receiver sees an idle line out of reset.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   rx   : asynchronous serial input
//   rx_s : synchronised copy of rx, SYNC_STAGES cycles late
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the raw pin through the flop chain. Reset loads all ones, which
    // matches an idle (marking) line and avoids a false start after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Detects the start edge, samples each bit at its centre
// and presents each good byte on a parallel bus with a one-cycle strobe.
//   clk       : system clock, all logic on the rising edge
//   rst       : synchronous, active-high reset
//   rx        : asynchronous serial input, idles high
//   data      : last correctly received byte, held until the next good frame
//   valid     : one-cycle pulse, data is new this cycle
//   frame_err : one-cycle pulse, stop bit was sampled low
//   busy      : high whenever the receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    // The cycle counter restarts at zero on entry to each state, and the first
    // cycle of START is already one cycle after the start edge was seen in
    // IDLE. Comparing against HALF-1 therefore lands the start sample on cycle
    // HALF counted from that edge; full bit periods then follow at BIT_LAST.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    // State and datapath registers. Reset aborts any frame in progress and
    // clears the output byte, so no pulse can come out of a half-received
    // frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state and datapath logic. Every sample point is a single cycle
    // where the cycle counter hits its terminal value. Within DATA the counter
    // wraps each bit period; any state change clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                // Mid start bit: a line back high means the edge was a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                // Shift in from the top so the first (LSB) bit ends in bit 0.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                // Return to IDLE at mid stop bit so a start edge right after
                // the stop bit is caught with half a bit of margin.
                if (cnt_q == BIT_LAST) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end

            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Pulses are gated with rst so they can never be seen while reset is held,
    // even in the cycle where rst rises before the registers clear.
    assign data      = data_q;
    assign valid     = valid_q & ~rst;
    assign frame_err = ferr_q & ~rst;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx with CLKS_PER_BIT=16. The serial
// transmitter is modelled in the bench with a real-valued bit time, so the
// same task covers the nominal baud and a +/-2% skewed transmitter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int      CPB    = 16;
    localparam int      SYNC   = 2;
    localparam realtime CLK_NS = 10.0;
    localparam realtime BIT_NS = CPB * CLK_NS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int assert_count  = 0;
    int fail_count    = 0;
    int valid_count   = 0;
    int ferr_count    = 0;
    int overlap_count = 0;
    logic [7:0] rx_bytes[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Observe outputs on the falling edge: count pulses, log bytes, and note
    // any cycle where the pulses collide or appear during reset.
    always @(negedge clk) begin
        if (valid) begin
            valid_count++;
            rx_bytes.push_back(data);
        end
        if (frame_err) begin
            ferr_count++;
        end
        if ((valid && frame_err) || (rst && (valid || frame_err))) begin
            overlap_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one 8N1 frame starting now; the line is left at the stop level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_val,
                                 input realtime bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byteAt(input int i);
        if (rx_bytes.size() > i) return rx_bytes[i];
        return 8'hxx;
    endfunction

    task automatic clearCounts();
        valid_count = 0;
        ferr_count  = 0;
        rx_bytes.delete();
    endtask

    initial begin
        realtime skew_ns[3];
        skew_ns[0] = BIT_NS;
        skew_ns[1] = BIT_NS * 1.02;
        skew_ns[2] = BIT_NS * 0.98;

        rst = 1'b1;
        rx  = 1'b1;
        waitCycles(4);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        waitCycles(3);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Single frame 0xA4 with exact latency: valid rises on the 155th
        // rising edge after the falling edge (8 + 144 + 1 + 2).
        $display("[TB] frame 0xA4 latency");
        clearCounts();
        fork
            applyStimulus(8'hA4, 1'b1, BIT_NS);
            begin
                repeat (154) @(posedge clk);
                #1;
                checkOutput("a4_valid_early", 32'(valid), 32'd0);
                @(posedge clk);
                #1;
                checkOutput("a4_valid_on_time", 32'(valid), 32'd1);
                checkOutput("a4_data", 32'(data), 32'hA4);
                @(posedge clk);
                #1;
                checkOutput("a4_valid_one_cycle", 32'(valid), 32'd0);
            end
        join
        waitCycles(20);
        checkOutput("a4_valid_count", 32'(valid_count), 32'd1);
        checkOutput("a4_frame_err_count", 32'(ferr_count), 32'd0);

        // Back-to-back frames with no idle gap.
        $display("[TB] back-to-back 0x00 0xFF 0x55");
        clearCounts();
        applyStimulus(8'h00, 1'b1, BIT_NS);
        applyStimulus(8'hFF, 1'b1, BIT_NS);
        applyStimulus(8'h55, 1'b1, BIT_NS);
        waitCycles(20);
        checkOutput("b2b_count", 32'(valid_count), 32'd3);
        checkOutput("b2b_byte0", 32'(byteAt(0)), 32'h00);
        checkOutput("b2b_byte1", 32'(byteAt(1)), 32'hFF);
        checkOutput("b2b_byte2", 32'(byteAt(2)), 32'h55);

        // Five-cycle low glitch: START is left at cycle H, busy low at H+1.
        $display("[TB] 5-cycle glitch");
        clearCounts();
        rx = 1'b0;
        waitCycles(5);
        rx = 1'b1;
        waitCycles(5);
        checkOutput("glitch_busy_in_start", 32'(busy), 32'd1);
        waitCycles(1);
        checkOutput("glitch_busy_released", 32'(busy), 32'd0);
        waitCycles(20);
        checkOutput("glitch_no_valid", 32'(valid_count), 32'd0);
        checkOutput("glitch_no_frame_err", 32'(ferr_count), 32'd0);

        // Bad stop bit followed by a held-low line.
        $display("[TB] frame 0x3C with low stop, then break");
        clearCounts();
        applyStimulus(8'h3C, 1'b0, BIT_NS);
        waitCycles(100);
        checkOutput("break_frame_err_count", 32'(ferr_count), 32'd1);
        checkOutput("break_no_valid", 32'(valid_count), 32'd0);
        checkOutput("break_data_kept", 32'(data), 32'h55);
        checkOutput("break_state", 32'(dut.state_q), 32'(BREAK));
        checkOutput("break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        waitCycles(10);
        checkOutput("break_released", 32'(busy), 32'd0);
        applyStimulus(8'h81, 1'b1, BIT_NS);
        waitCycles(20);
        checkOutput("after_break_data", 32'(data), 32'h81);
        checkOutput("after_break_valid_count", 32'(valid_count), 32'd1);
        checkOutput("after_break_frame_err_count", 32'(ferr_count), 32'd1);

        // Reset for one cycle in the middle of data bit 4.
        $display("[TB] reset during data bit 4");
        clearCounts();
        fork
            applyStimulus(8'hF2, 1'b1, BIT_NS);
            begin
                repeat (88) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                checkOutput("midreset_data", 32'(data), 32'h00);
                checkOutput("midreset_busy", 32'(busy), 32'd0);
            end
        join
        waitCycles(20);
        checkOutput("midreset_no_valid", 32'(valid_count), 32'd0);
        checkOutput("midreset_no_frame_err", 32'(ferr_count), 32'd0);
        checkOutput("midreset_data_after", 32'(data), 32'h00);
        applyStimulus(8'h7E, 1'b1, BIT_NS);
        waitCycles(20);
        checkOutput("midreset_next_data", 32'(data), 32'h7E);
        checkOutput("midreset_next_count", 32'(valid_count), 32'd1);

        // Message 0xA4, 0xFF at nominal, +2% and -2% transmitter bit time.
        for (int k = 0; k < 3; k++) begin
            $display("[TB] loopback message, bit time %0.1f ns", skew_ns[k]);
            clearCounts();
            applyStimulus(8'hA4, 1'b1, skew_ns[k]);
            applyStimulus(8'hFF, 1'b1, skew_ns[k]);
            waitCycles(30);
            checkOutput($sformatf("loop%0d_count", k), 32'(valid_count), 32'd2);
            checkOutput($sformatf("loop%0d_byte0", k), 32'(byteAt(0)), 32'hA4);
            checkOutput($sformatf("loop%0d_byte1", k), 32'(byteAt(1)), 32'hFF);
            checkOutput($sformatf("loop%0d_frame_err", k), 32'(ferr_count), 32'd0);
        end

        checkOutput("pulse_exclusive", 32'(overlap_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver for the UART_LITE path, sitting directly downstream of uart_tx on the serial line. It deserialises 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) from the asynchronous rx pin. Each good byte is presented on a parallel bus with a one-cycle valid strobe. It shares its baud configuration with uart_tx so the pair can be looped back (tx -> rx) for bring-up and self-test.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 4
SYNC_STAGES, 2, flops in the rx input synchroniser; legal range >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial input; idles high
data  output  8  last correctly received byte; held until next good frame
valid  output  1  one-cycle pulse; data is new this cycle
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, counters=0, synchroniser flops=1 (line idle).
- rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- H = CLKS_PER_BIT/2 (integer division). Bit counter: 3 bits. Cycle counter: $clog2(CLKS_PER_BIT) bits, cleared on every state change.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START.
  - Define cycle 0 as the first IDLE cycle with rx_s==0.
- START:
  - Sample rx_s at cycle H (mid start bit).
  - rx_s==0 -> DATA, bit counter=0.
  - rx_s==1 -> IDLE as a false start/glitch; no output pulse.
- DATA:
  - Data bit i (i=0..7) is sampled at cycle H+(i+1)*CLKS_PER_BIT.
  - Each sample is shifted into an internal shift register, LSB first.
  - After bit 7 -> STOP.
- STOP:
  - Sample rx_s at cycle H+9*CLKS_PER_BIT.
  - Sample high: data<=shift register; valid=1 on the next cycle (cycle H+9*CLKS_PER_BIT+1) for exactly 1 cycle; state -> IDLE.
  - Sample low: frame_err=1 for 1 cycle; data unchanged; state -> BREAK.
- BREAK:
  - Stay until rx_s==1, then -> IDLE.
  - This prevents a held-low line (break) from being decoded as 0x00 frames.
- Back-to-back frames:
  - Return to IDLE occurs at mid stop bit, leaving half a bit of margin.
  - A start edge arriving immediately after the stop bit must be accepted; there are no dead cycles required beyond the stop bit.
- valid and frame_err are never high in the same cycle and are never high while rst=1.
- Reset mid-frame: the next clk edge with rst=1 aborts the frame. No valid or frame_err is produced. data returns to 8'h00.
- Baud tolerance: receive correctly with the transmitter off by up to ±2% of CLKS_PER_BIT.
- No input buffering: the consumer must take data within one frame time, or the byte is overwritten by the next good frame.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE, START, DATA, STOP, BREAK);
  - default CLKS_PER_BIT constant shared with uart_tx;
  - frame-format constants (DATA_BITS=8, STOP_BITS=1).
- Sub-module uart_rx_sync: the SYNC_STAGES-deep synchroniser with reset value 1.

Test Plan (CLKS_PER_BIT=16 in simulation unless noted):
1. Drive the frame for 0xA4 on rx -> valid pulses once, data=8'hA4, exactly H+9*16+1+SYNC_STAGES cycles after the rx falling edge; frame_err stays 0.
2. Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses, with data=00, FF, 55 in order.
3. Low glitch of 5 cycles on an idle line -> no valid, no frame_err; busy returns to 0 by cycle H+1.
4. Frame 0x3C with stop bit forced 0, then rx held low for 100 cycles before release -> one frame_err pulse and no valid; data keeps its previous value; state stays BREAK until release. A following 0x81 frame is then received correctly.
5. Assert rst for 1 cycle during data bit 4 of a frame -> no valid, data=00. The remainder of the aborted frame must not produce a spurious byte; the next clean 0x7E frame is received correctly.
6. Loopback uart_tx.tx -> uart_rx.rx at the shared CLKS_PER_BIT, sending message 0xA4 then 0xFF -> rx data matches each byte. Repeat with the tx clock divisor offset +2% -> same result.
